// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the Lisp memory-port arbiter: memory geometry,
// arbiter defaults and the arbiter state encoding.
package mem_arbiter_pkg;

    localparam int addr_width       = 12;
    localparam int data_width       = 8;
    localparam int MEM_READ_LATENCY = 1;
    localparam int NUM_MEM_REQ      = 3;

    typedef enum logic [1:0] {
        ArbBoot,
        ArbIdle,
        ArbIssue,
        ArbWait
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping,
// returned both as a one-hot vector and as an index.
module rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win_onehot,
    output logic [IDX_W-1:0]   win_idx,
    output logic               win_valid
);

    // Two passes keep every select index a loop constant: upper segment first, then the wrap.
    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        win_valid  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_valid && req[i] && (i >= int'(ptr))) begin
                win_valid     = 1'b1;
                win_onehot[i] = 1'b1;
                win_idx       = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_valid && req[i] && (i < int'(ptr))) begin
                win_valid     = 1'b1;
                win_onehot[i] = 1'b1;
                win_idx       = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the single memory_controller port between requesters.
// Define MEM_ARB_LOCK_EN to let a requester hold the port across transactions via req_lock.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = NUM_MEM_REQ,
    parameter int ADDR_W       = addr_width,
    parameter int DATA_W       = data_width,
    parameter int READ_LATENCY = MEM_READ_LATENCY
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      boot_done,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]        req_lock,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_we,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic                      busy
);

    // state    | meaning
    // ArbBoot  | memory preload running, all grants held off
    // ArbIdle  | arbitrating; mem_addr keeps the last transaction's address
    // ArbIssue | gnt pulse; a write commits at the end of this cycle
    // ArbWait  | counting down the read latency, then rdata/rvalid

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = 3;

    arb_state_t         state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   w_idx;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_REQ-1:0] pick_req;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;

`ifdef MEM_ARB_LOCK_EN
    logic lock_hold;
    logic lock_act;

    // While the last winner keeps its lock, only that winner may be picked.
    assign lock_act = lock_hold && req_lock[w_idx];
    assign pick_req = lock_act ? (req & (NUM_REQ'(1) << w_idx)) : req;
`else
    logic unused_lock;

    assign unused_lock = ^req_lock;
    assign pick_req    = req;
`endif

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_picker (
        .req        (pick_req),
        .ptr        (ptr),
        .win_onehot (pick_onehot),
        .win_idx    (pick_idx),
        .win_valid  (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ArbBoot;
            gnt       <= '0;
            rvalid    <= '0;
            rdata     <= '0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            busy      <= 1'b1;
            ptr       <= '0;
            w_idx     <= '0;
            cnt       <= '0;
`ifdef MEM_ARB_LOCK_EN
            lock_hold <= 1'b0;
`endif
        end else begin
            gnt    <= '0;
            rvalid <= '0;
            mem_we <= 1'b0;
            case (state)
                ArbBoot: begin
                    if (boot_done) begin
                        state <= ArbIdle;
                        busy  <= 1'b0;
                    end
                end
                ArbIdle: begin
`ifdef MEM_ARB_LOCK_EN
                    if (!req_lock[w_idx]) lock_hold <= 1'b0;
`endif
                    if (pick_valid) begin
                        gnt       <= pick_onehot;
                        w_idx     <= pick_idx;
                        mem_addr  <= req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                        mem_wdata <= req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
                        mem_we    <= req_we[pick_idx];
                        ptr       <= (pick_idx == IDX_W'(NUM_REQ-1)) ? '0 : pick_idx + 1'b1;
                        state     <= ArbIssue;
                        busy      <= 1'b1;
                    end
                end
                ArbIssue: begin
                    // mem_we still holds the latched direction during ISSUE
                    if (mem_we) begin
                        state <= ArbIdle;
                        busy  <= 1'b0;
`ifdef MEM_ARB_LOCK_EN
                        lock_hold <= req_lock[w_idx];
`endif
                    end else begin
                        cnt   <= CNT_W'(READ_LATENCY-1);
                        state <= ArbWait;
                    end
                end
                ArbWait: begin
                    if (cnt == '0) begin
                        rdata         <= mem_rdata;
                        rvalid[w_idx] <= 1'b1;
                        state         <= ArbIdle;
                        busy          <= 1'b0;
`ifdef MEM_ARB_LOCK_EN
                        lock_hold <= req_lock[w_idx];
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ArbBoot;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-ported Lisp memory_controller port between N requesters: eval core, cons allocator/GC, debug/display reader.
- Round-robin arbitration with a req/gnt handshake and one outstanding transaction at a time.
- Hides the synchronous read latency behind a per-requester rvalid pulse.
- Sits between the requesters and memory_controller; holds all grants until boot_done.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDR_W, lisp::addr_width (12), memory address width.
- DATA_W, lisp::data_width (8), memory data width.
- READ_LATENCY, 1, cycles from mem_addr presented to mem_rdata valid (1..4).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- boot_done  in  1  memory preload complete
- req  in  NUM_REQ  request per requester
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  flattened write data
- req_lock  in  NUM_REQ  hold-grant request; only used with MEM_ARB_LOCK_EN
- gnt  out  NUM_REQ  one-hot, 1-cycle pulse; request accepted
- rvalid  out  NUM_REQ  one-hot, 1-cycle pulse; rdata valid for that requester
- rdata  out  DATA_W  registered read data, shared by all requesters
- mem_addr  out  ADDR_W  to memory_controller addr
- mem_we  out  1  to memory_controller write_enable
- mem_wdata  out  DATA_W  to memory_controller write_data
- mem_rdata  in  DATA_W  from memory_controller read_data
- busy  out  1  high in any state other than IDLE

Behaviour:
- All outputs are registered. Reset values: gnt=0, rvalid=0, rdata=0, mem_addr=0, mem_we=0, mem_wdata=0, busy=1 (in BOOT). Round-robin pointer resets to 0. Reset takes effect mid-transaction: the in-flight read produces no rvalid, and mem_we drops on the next edge.
- FSM states:
  - BOOT: stay until boot_done=1, then go to IDLE.
  - IDLE: if any req is high, choose winner w = first requester with req high at or after the pointer, wrapping around. On the same edge register mem_addr/mem_we/mem_wdata from w, set gnt[w]=1, latch w, go to ISSUE. If no req is high, stay in IDLE with mem_we=0.
  - ISSUE (gnt[w] high this cycle only):
    - Write: mem_we=1 for this single cycle; the write commits at the end of ISSUE; go to IDLE.
    - Read: go to WAIT with the counter loaded with READ_LATENCY-1.
  - WAIT: decrement the counter. When it reaches 0, capture rdata<=mem_rdata, pulse rvalid[w] in the following cycle, and go to IDLE in that same cycle.
- Timing:
  - Read: req sampled at edge 0, gnt in cycle 1, rvalid in cycle 2+READ_LATENCY.
  - Write: 2 cycles per transaction, IDLE→ISSUE.
- Pointer update: set to (w+1) mod NUM_REQ on every grant.
- Handshake rules:
  - A requester holds req/req_we/req_addr/req_wdata stable until it sees gnt.
  - A requester may drop req before gnt (withdrawn request); this is never an error.
  - After gnt, a requester must drop req or present a new transaction in the next cycle; the arbiter does not sample req outside IDLE.
- Simultaneous events:
  - All requesters high: strict rotation.
  - A single requester holding req continuously: back-to-back grants every 2 cycles for writes, every 2+READ_LATENCY cycles for reads.
  - The mem_addr of the last transaction is held while idle; only mem_we returns to 0.

Optional Feature:
- Macro: MEM_ARB_LOCK_EN (atomic read-modify-write for cons/GC).
- With the macro defined:
  - If req_lock[w] is high when w returns to IDLE, the pointer is not advanced.
  - Arbitration considers only requester w while req_lock[w] stays high; other requests stall, with no gnt.
  - Dropping req_lock restores normal round-robin starting at w+1.
- Without the macro: req_lock is ignored (port kept, unused) and behaviour is pure round-robin.

Decomposition:
- Add to the lisp package:
  - typedef arb_state_t {ArbBoot, ArbIdle, ArbIssue, ArbWait}.
  - Constants MEM_READ_LATENCY=1 and NUM_MEM_REQ=3.
- One sub-module, rr_picker: combinational, req + pointer → one-hot winner and index. Instantiate it once.

Test Plan:
- Hold boot_done=0 for 10 cycles with req=3'b001 → no gnt, busy=1. Raise boot_done → gnt[0] within 2 cycles of the following edge.
- Req0 reads addr 12'h010 (preloaded 8'h2A), READ_LATENCY=1 → gnt[0] in cycle 1, rvalid[0] in cycle 3 with rdata=8'h2A.
- Req=3'b111 held continuously, all reads → grant order 0,1,2,0,1,2; no requester starved; exactly one gnt/rvalid bit high at any time.
- Req1 writes 8'h55 to 12'h0FF, then req2 reads 12'h0FF → mem_we high for exactly 1 cycle, and req2 gets rvalid with rdata=8'h55.
- Assert rst during WAIT of a req0 read → no rvalid[0]; all outputs at reset values on the next cycle; FSM in BOOT.
- With MEM_ARB_LOCK_EN: req0 holds req_lock for a read then a write while req1 is requesting → req0 gets both grants consecutively; req1 gets gnt only after req_lock drops.
